regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 32 x 32-bit register file. It shares the register file's single write port between two producers, the ALU result path and the load/memory return path, using round-robin arbitration with a valid/ready handshake. It also tracks destination registers that have been reserved at issue but not yet written, and raises a hazard flag so the decode stage can stall dependent reads. It sits between execute/memory and the register file write port (enable, write address, write data).

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register index width (32 registers)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU has a writeback pending
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU writeback accepted this cycle
- mem_valid  in  1  load has a writeback pending
- mem_reg  in  5  load destination register
- mem_data  in  32  load data
- mem_ready  out  1  load writeback accepted this cycle
- rsv_valid  in  1  issue stage reserves a destination this cycle
- rsv_reg  in  5  destination register being reserved
- chk_reg1, chk_reg2  in  5 each  source registers of the instruction in decode
- hazard  out  1  a checked source has an outstanding write
- pending  out  32  scoreboard; bit i set means register i awaits writeback
- rf_enable  out  1  register file write enable
- rf_writeReg  out  5  register file write address
- rf_writeData  out  32  register file write data

## Operation
- Transfer: a source transfers on a rising edge where its valid and ready are both 1.
- Arbitration is combinational from valid and the priority bit `prio` (0 = ALU favoured, 1 = load favoured).
  - One source valid: that source gets ready=1.
  - Both valid: the favoured source gets ready=1; the other gets ready=0 and must hold valid, reg and data stable.
  - Neither valid: both ready=0.
- After any transfer, `prio` points to the source that did not win. With no transfer, `prio` is unchanged.
- Throughput: one writeback per cycle. The write port never back-pressures.
- Output register: on a transfer, rf_writeReg and rf_writeData load the winner's reg/data on that edge. rf_enable is set to 1 if the reg is nonzero, else 0. With no transfer, rf_enable is 0 and address/data hold their previous values.
- Register 0: a writeback to register 0 is accepted (ready asserted normally) and discarded. It is never reserved or marked pending.
- Scoreboard:
  - rsv_valid with rsv_reg≠0 sets pending[rsv_reg].
  - An edge where rf_enable=1 clears pending[rf_writeReg]. This is the commit edge at which the register file latches the data.
  - Set and clear on the same register in the same edge: set wins, because the newer producer owns the register.
  - A writeback to an unreserved register is legal and only clears the bit if it is set.
  - pending[0] is always 0.
- hazard = (chk_reg1≠0 and pending[chk_reg1]) or (chk_reg2≠0 and pending[chk_reg2]). It is combinational from the current pending value.

## Timing
- Reset, synchronous, takes effect at the first rising edge with rst=1. rst overrides all other activity in the same edge.
  - rf_enable=0, rf_writeReg=0, rf_writeData=0.
  - pending=0, hazard=0 (for any chk input), prio=0.
  - alu_ready and mem_ready follow the combinational rules with prio=0.
  - Transfers in progress at that edge are dropped.
- Latency:
  - Transfer at edge N: rf_enable/address/data valid during cycle N→N+1.
  - Register file commits at edge N+1; pending bit clears at edge N+1.
  - hazard for that register drops in cycle N+1→N+2.
- Reservation at edge R: hazard for rsv_reg is visible from cycle R→R+1 onward.
- A reservation and a transfer for the same register on the same edge: the bit is set at that edge and cleared at the following commit edge.
- A stalled source sees ready=0 for at most one cycle while the other source stays continuously valid (round-robin fairness).

## Test plan
- Single ALU write: reset, then alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF for one cycle. Required: alu_ready=1; next cycle rf_enable=1, rf_writeReg=5, rf_writeData=0xDEADBEEF; the cycle after, rf_enable=0.
- Contention: both valid continuously for 4 cycles (alu_reg=1, mem_reg=2), prio reset. Required grant order ALU, MEM, ALU, MEM; rf_writeReg sequence 1, 2, 1, 2; the loser's ready=0 each cycle.
- Scoreboard: reserve reg 7, chk_reg1=7. Required: hazard=1 from the next cycle. mem writes reg 7 at edge N; hazard stays 1 through cycle N→N+1 and is 0 from N+1; pending[7] ends at 0.
- Set/clear collision: reg 9 pending and committing at edge E while rsv_reg=9 is reserved at E. Required: pending[9]=1 after E; hazard remains 1 for chk_reg2=9.
- Register 0: alu writes reg 0 and rsv_reg=0 is reserved. Required: alu_ready=1, rf_enable=0 next cycle, pending=0, hazard=0 with chk_reg1=0.
- Reset mid-operation: pending=0x0000_00F0, ALU transfer in flight, rst=1 for one edge. Required: after that edge pending=0, rf_enable=0, rf_writeReg=0, rf_writeData=0, prio=0 (ALU wins the next contention).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between the ALU result path
// and the load return path. Arbitration is round-robin over a valid/ready
// handshake. A scoreboard tracks destination registers that were reserved at
// issue and have not yet been committed. The decode stage reads `hazard` to
// stall instructions that depend on those registers.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   alu_valid/reg/data       ALU writeback request (held stable while stalled)
//   alu_ready                ALU writeback accepted on this edge
//   mem_valid/reg/data       load writeback request (held stable while stalled)
//   mem_ready                load writeback accepted on this edge
//   rsv_valid, rsv_reg       destination reservation from the issue stage
//   chk_reg1, chk_reg2       source registers of the instruction in decode
//   hazard                   a checked source has an outstanding write
//   pending                  scoreboard, bit i = register i awaits writeback
//   rf_enable/writeReg/Data  registered register file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       alu_valid,
  input  logic [ADDR_WIDTH-1:0]      alu_reg,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       alu_ready,

  input  logic                       mem_valid,
  input  logic [ADDR_WIDTH-1:0]      mem_reg,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_ready,

  input  logic                       rsv_valid,
  input  logic [ADDR_WIDTH-1:0]      rsv_reg,
  input  logic [ADDR_WIDTH-1:0]      chk_reg1,
  input  logic [ADDR_WIDTH-1:0]      chk_reg2,
  output logic                       hazard,
  output logic [(1<<ADDR_WIDTH)-1:0] pending,

  output logic                       rf_enable,
  output logic [ADDR_WIDTH-1:0]      rf_writeReg,
  output logic [DATA_WIDTH-1:0]      rf_writeData
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Priority bit: 0 = ALU favoured, 1 = load favoured.
  logic                  prio_q, prio_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  rf_enable_q, rf_enable_d;
  logic [ADDR_WIDTH-1:0] rf_writeReg_q, rf_writeReg_d;
  logic [DATA_WIDTH-1:0] rf_writeData_q, rf_writeData_d;

  // ---------------------------------------------------------------------------
  // Arbitration. Ready implies valid, so ready alone marks a transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_ready = alu_valid & (~mem_valid | ~prio_q);
    mem_ready = mem_valid & (~alu_valid |  prio_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the priority bit, the write port and the scoreboard.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so that no path leaves one
    // unassigned, which would otherwise infer a latch.
    prio_d         = prio_q;
    rf_enable_d    = 1'b0;
    rf_writeReg_d  = rf_writeReg_q;
    rf_writeData_d = rf_writeData_q;
    pending_d      = pending_q;

    // The winner's turn ends: priority moves to the source that lost.
    if (alu_ready) begin
      prio_d         = 1'b1;
      rf_enable_d    = (alu_reg != '0);
      rf_writeReg_d  = alu_reg;
      rf_writeData_d = alu_data;
    end else if (mem_ready) begin
      prio_d         = 1'b0;
      rf_enable_d    = (mem_reg != '0);
      rf_writeReg_d  = mem_reg;
      rf_writeData_d = mem_data;
    end

    // Clear on the commit edge, then set, so a new reservation of the same
    // register wins: the newer producer owns it.
    if (rf_enable_q) begin
      pending_d[rf_writeReg_q] = 1'b0;
    end
    if (rsv_valid && (rsv_reg != '0)) begin
      pending_d[rsv_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      // The scoreboard is a plain flop vector, not a RAM, so it can and must
      // be cleared here; otherwise stale pending bits would stall decode.
      prio_q         <= 1'b0;
      pending_q      <= '0;
      rf_enable_q    <= 1'b0;
      rf_writeReg_q  <= '0;
      rf_writeData_q <= '0;
    end else begin
      prio_q         <= prio_d;
      pending_q      <= pending_d;
      rf_enable_q    <= rf_enable_d;
      rf_writeReg_q  <= rf_writeReg_d;
      rf_writeData_q <= rf_writeData_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard = ((chk_reg1 != '0) && pending_q[chk_reg1]) ||
             ((chk_reg2 != '0) && pending_q[chk_reg2]);
  end

  assign pending      = pending_q;
  assign rf_enable    = rf_enable_q;
  assign rf_writeReg  = rf_writeReg_q;
  assign rf_writeData = rf_writeData_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Applies a table of directed cycles to regfile_wb_arbiter. For each row, the
// ready outputs are compared before the clock edge. The write port, the
// scoreboard and hazard are compared after the edge. A short hand-written
// sequence covers a reservation and a transfer to the same register on the
// same edge. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_reg, mem_reg, rsv_reg, chk_reg1, chk_reg2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hazard, rf_enable;
  logic [31:0] pending;
  logic [4:0]  rf_writeReg;
  logic [31:0] rf_writeData;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .rsv_valid    (rsv_valid),
    .rsv_reg      (rsv_reg),
    .chk_reg1     (chk_reg1),
    .chk_reg2     (chk_reg2),
    .hazard       (hazard),
    .pending      (pending),
    .rf_enable    (rf_enable),
    .rf_writeReg  (rf_writeReg),
    .rf_writeData (rf_writeData)
  );

  typedef struct {
    // inputs
    bit          rst;
    bit          av;
    logic [4:0]  areg;
    logic [31:0] adata;
    bit          mv;
    logic [4:0]  mreg;
    logic [31:0] mdata;
    bit          rv;
    logic [4:0]  rreg;
    logic [4:0]  c1;
    logic [4:0]  c2;
    // expected: readies before the edge
    bit          e_ar;
    bit          e_mr;
    // expected: state after the edge
    bit          e_en;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    bit          e_haz;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    alu_valid = v.av;
    alu_reg   = v.areg;
    alu_data  = v.adata;
    mem_valid = v.mv;
    mem_reg   = v.mreg;
    mem_data  = v.mdata;
    rsv_valid = v.rv;
    rsv_reg   = v.rreg;
    chk_reg1  = v.c1;
    chk_reg2  = v.c2;
  endtask

  initial begin
    //           rst av areg adata         mv mreg mdata   rv rreg c1  c2   ar mr en reg data          pend          haz
    // Reset
    vecs[0]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  0,   0, 0, 0, 0,  32'h0,        32'h0,        0};
    // Single ALU write to reg 5, then idle
    vecs[1]  = '{0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,  0, 0,   0,  0,   1, 0, 1, 5,  32'hDEADBEEF, 32'h0,        0};
    vecs[2]  = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  0,   0, 0, 0, 5,  32'hDEADBEEF, 32'h0,        0};
    // Reset prio, then four cycles of contention: ALU, MEM, ALU, MEM
    vecs[3]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  0,   0, 0, 0, 0,  32'h0,        32'h0,        0};
    vecs[4]  = '{0, 1, 1,  32'h11,        1, 2,  32'h22, 0, 0,   0,  0,   1, 0, 1, 1,  32'h11,       32'h0,        0};
    vecs[5]  = '{0, 1, 1,  32'h11,        1, 2,  32'h22, 0, 0,   0,  0,   0, 1, 1, 2,  32'h22,       32'h0,        0};
    vecs[6]  = '{0, 1, 1,  32'h11,        1, 2,  32'h22, 0, 0,   0,  0,   1, 0, 1, 1,  32'h11,       32'h0,        0};
    vecs[7]  = '{0, 1, 1,  32'h11,        1, 2,  32'h22, 0, 0,   0,  0,   0, 1, 1, 2,  32'h22,       32'h0,        0};
    vecs[8]  = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  0,   0, 0, 0, 2,  32'h22,       32'h0,        0};
    // Scoreboard: reserve 7, load writes 7, hazard drops one cycle after commit
    vecs[9]  = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 7,   7,  0,   0, 0, 0, 2,  32'h22,       32'h80,       1};
    vecs[10] = '{0, 0, 0,  32'h0,         1, 7,  32'h77, 0, 0,   7,  0,   0, 1, 1, 7,  32'h77,       32'h80,       1};
    vecs[11] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   7,  0,   0, 0, 0, 7,  32'h77,       32'h0,        0};
    // Set/clear collision on reg 9 (checked via chk_reg2)
    vecs[12] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 9,   0,  9,   0, 0, 0, 7,  32'h77,       32'h200,      1};
    vecs[13] = '{0, 1, 9,  32'h99,        0, 0,  32'h0,  0, 0,   0,  9,   1, 0, 1, 9,  32'h99,       32'h200,      1};
    vecs[14] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 9,   0,  9,   0, 0, 0, 9,  32'h99,       32'h200,      1};
    vecs[15] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  9,   0, 0, 0, 9,  32'h99,       32'h200,      1};
    // Retire reg 9 via the load path
    vecs[16] = '{0, 0, 0,  32'h0,         1, 9,  32'h1,  0, 0,   0,  9,   0, 1, 1, 9,  32'h1,        32'h200,      1};
    vecs[17] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  0, 0,   0,  9,   0, 0, 0, 9,  32'h1,        32'h0,        0};
    // Register 0: accepted, discarded, never reserved
    vecs[18] = '{0, 1, 0,  32'hABCD,      0, 0,  32'h0,  1, 0,   0,  0,   1, 0, 0, 0,  32'hABCD,     32'h0,        0};
    // Build pending = 0xF0 with an ALU transfer in flight, then reset
    vecs[19] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 4,   6,  0,   0, 0, 0, 0,  32'hABCD,     32'h10,       0};
    vecs[20] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 5,   6,  0,   0, 0, 0, 0,  32'hABCD,     32'h30,       0};
    vecs[21] = '{0, 0, 0,  32'h0,         0, 0,  32'h0,  1, 6,   6,  0,   0, 0, 0, 0,  32'hABCD,     32'h70,       1};
    vecs[22] = '{0, 1, 3,  32'h33,        0, 0,  32'h0,  1, 7,   6,  0,   1, 0, 1, 3,  32'h33,       32'hF0,       1};
    vecs[23] = '{1, 1, 4,  32'h44,        0, 0,  32'h0,  0, 0,   6,  0,   1, 0, 0, 0,  32'h0,        32'h0,        0};
    // prio back to 0: ALU wins the next contention
    vecs[24] = '{0, 1, 1,  32'h11,        1, 2,  32'h22, 0, 0,   0,  0,   1, 0, 1, 1,  32'h11,       32'h0,        0};

    drive(vecs[0]);

    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) begin
        @(negedge clk);
        drive(vecs[i]);
      end
      #1;
      if (i > 0) begin
        check($sformatf("v%0d.alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ar});
        check($sformatf("v%0d.mem_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].e_mr});
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d.rf_enable", i),    {31'b0, rf_enable}, {31'b0, vecs[i].e_en});
      check($sformatf("v%0d.rf_writeReg", i),  {27'b0, rf_writeReg}, {27'b0, vecs[i].e_reg});
      check($sformatf("v%0d.rf_writeData", i), rf_writeData, vecs[i].e_data);
      check($sformatf("v%0d.pending", i),      pending, vecs[i].e_pend);
      check($sformatf("v%0d.hazard", i),       {31'b0, hazard}, {31'b0, vecs[i].e_haz});
    end

    // Reservation and transfer of reg 12 on the same edge: set at that edge,
    // cleared at the following commit edge. prio is 1 here, load idle.
    @(negedge clk);
    rst = 0; alu_valid = 1; alu_reg = 12; alu_data = 32'hC;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    rsv_valid = 1; rsv_reg = 12; chk_reg1 = 12; chk_reg2 = 0;
    #1;
    check("same_edge.alu_ready", {31'b0, alu_ready}, 32'd1);
    check("same_edge.hazard_pre", {31'b0, hazard}, 32'd0);
    @(posedge clk);
    #1;
    check("same_edge.rf_enable", {31'b0, rf_enable}, 32'd1);
    check("same_edge.rf_writeReg", {27'b0, rf_writeReg}, 32'd12);
    check("same_edge.pending_set", pending, 32'h1000);
    check("same_edge.hazard_set", {31'b0, hazard}, 32'd1);
    @(negedge clk);
    alu_valid = 0; rsv_valid = 0;
    #1;
    check("same_edge.hazard_commit_cycle", {31'b0, hazard}, 32'd1);
    @(posedge clk);
    #1;
    check("same_edge.pending_clear", pending, 32'h0);
    check("same_edge.hazard_clear", {31'b0, hazard}, 32'd0);
    check("same_edge.rf_enable_off", {31'b0, rf_enable}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
